// File: rtl/rib_arbiter.sv
// Two-master / one-slave round-robin bus arbiter with registered req/ack handshake.
// Optional slave-response timeout is enabled by defining ARB_TIMEOUT_EN.
module rib_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic [31:0] s_rdata_i,
    input  logic        s_ack_i,
    output logic        hold_flag_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_next;
    logic   owner;
    logic   last_owner;
    logic   grant_valid;
    logic   grant_sel;
    logic   abort;
    logic   done;

    if (TIMEOUT < 2 || TIMEOUT > 255 || (1 << CNT_W) <= TIMEOUT) begin : g_bad_cfg
        $error("rib_arbiter: illegal TIMEOUT/CNT_W combination");
    end

    // Tie goes to whichever master did not own the previous transaction.
    always_comb begin
        grant_valid = m0_req_i | m1_req_i;
        grant_sel   = 1'b0;
        if (m0_req_i && m1_req_i)
            grant_sel = ~last_owner;
        else if (m1_req_i)
            grant_sel = 1'b1;
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    // Held at zero while idle, so every transaction starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state == IDLE)
            cnt <= '0;
        else if (!s_ack_i)
            cnt <= cnt + CNT_W'(1);
    end

    assign abort = (state == BUSY) && !s_ack_i && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_err_o <= 1'b0;
            m1_err_o <= 1'b0;
        end else begin
            m0_err_o <= abort && !owner;
            m1_err_o <= abort && owner;
        end
    end
`else
    assign abort    = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    assign done = (state == BUSY) && (s_ack_i || abort);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = BUSY;
            BUSY:    if (done)        state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            s_req_o    <= 1'b0;
            s_we_o     <= 1'b0;
            s_addr_o   <= '0;
            s_wdata_o  <= '0;
            m0_ack_o   <= 1'b0;
            m1_ack_o   <= 1'b0;
            m0_rdata_o <= '0;
            m1_rdata_o <= '0;
        end else begin
            state    <= state_next;
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;

            // Master inputs are only looked at here, at grant time.
            if (state == IDLE && grant_valid) begin
                owner     <= grant_sel;
                s_req_o   <= 1'b1;
                s_we_o    <= grant_sel ? m1_we_i    : m0_we_i;
                s_addr_o  <= grant_sel ? m1_addr_i  : m0_addr_i;
                s_wdata_o <= grant_sel ? m1_wdata_i : m0_wdata_i;
            end

            if (done) begin
                s_req_o    <= 1'b0;
                last_owner <= owner;
                if (owner) begin
                    m1_ack_o   <= 1'b1;
                    m1_rdata_o <= abort ? 32'h0 : s_rdata_i;
                end else begin
                    m0_ack_o   <= 1'b1;
                    m0_rdata_o <= abort ? 32'h0 : s_rdata_i;
                end
            end
        end
    end

    // Stall the pipe from load/store request until the cycle its ack appears.
    assign hold_flag_o = m0_req_i & ~m0_ack_o;

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed, table-driven bench for rib_arbiter; each table row is one clock cycle
// of inputs together with the outputs expected during that same cycle.
module tb_rib_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_req, s_we, s_ack, hold;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rib_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_rdata_i(s_rdata), .s_ack_i(s_ack), .hold_flag_o(hold)
    );

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        sa;
        logic [31:0] sd;
        logic        es, ew;
        logic [31:0] ea, ed;
        logic        k0;
        logic [31:0] q0;
        logic        k1;
        logic [31:0] q1;
        logic        h;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t V(
        input logic rst_v,
        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
        input logic sa, input logic [31:0] sd,
        input logic es, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
        input logic k0, input logic [31:0] q0, input logic k1, input logic [31:0] q1,
        input logic h);
        vec_t v;
        v.rst = rst_v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.sa = sa; v.sd = sd;
        v.es = es; v.ew = ew; v.ea = ea; v.ed = ed;
        v.k0 = k0; v.q0 = q0; v.k1 = k1; v.q1 = q1;
        v.h = h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        s_ack = 0; s_rdata = 0;

        // Single m0 read, latency and hold flag.
        vecs.push_back(V(1, 0,0,32'h0,32'h0,   0,0,32'h0,32'h0,     0,32'h0,        0,0,32'h0,32'h0,      0,32'h0,        0,32'h0, 0));
        vecs.push_back(V(0, 0,0,32'h0,32'h0,   0,0,32'h0,32'h0,     0,32'h0,        0,0,32'h0,32'h0,      0,32'h0,        0,32'h0, 0));
        vecs.push_back(V(0, 1,0,32'h100,32'h0, 0,0,32'h0,32'h0,     0,32'h0,        0,0,32'h0,32'h0,      0,32'h0,        0,32'h0, 1));
        vecs.push_back(V(0, 1,0,32'h100,32'h0, 0,0,32'h0,32'h0,     0,32'h0,        1,0,32'h100,32'h0,    0,32'h0,        0,32'h0, 1));
        vecs.push_back(V(0, 1,0,32'h100,32'h0, 0,0,32'h0,32'h0,     0,32'h0,        1,0,32'h100,32'h0,    0,32'h0,        0,32'h0, 1));
        vecs.push_back(V(0, 1,0,32'h100,32'h0, 0,0,32'h0,32'h0,     1,32'hDEADBEEF, 1,0,32'h100,32'h0,    0,32'h0,        0,32'h0, 1));
        vecs.push_back(V(0, 0,0,32'h100,32'h0, 0,0,32'h0,32'h0,     0,32'h0,        0,0,32'h100,32'h0,    1,32'hDEADBEEF, 0,32'h0, 0));
        vecs.push_back(V(0, 0,0,32'h100,32'h0, 0,0,32'h0,32'h0,     0,32'h0,        0,0,32'h100,32'h0,    0,32'hDEADBEEF, 0,32'h0, 0));
        // Continuous tie after reset: m0, m1, m0, m1 with one idle cycle between.
        vecs.push_back(V(1, 0,0,32'h0,32'h0,   0,0,32'h0,32'h0,     0,32'h0,        0,0,32'h0,32'h0,      0,32'h0,        0,32'h0, 0));
        vecs.push_back(V(0, 1,0,32'h10,32'h0,  1,0,32'h20,32'h0,    0,32'h0,        0,0,32'h0,32'h0,      0,32'h0,        0,32'h0, 1));
        vecs.push_back(V(0, 1,0,32'h10,32'h0,  1,0,32'h20,32'h0,    1,32'h11,       1,0,32'h10,32'h0,     0,32'h0,        0,32'h0, 1));
        vecs.push_back(V(0, 1,0,32'h10,32'h0,  1,0,32'h20,32'h0,    0,32'h0,        0,0,32'h10,32'h0,     1,32'h11,       0,32'h0, 0));
        vecs.push_back(V(0, 1,0,32'h10,32'h0,  1,0,32'h20,32'h0,    1,32'h22,       1,0,32'h20,32'h0,     0,32'h11,       0,32'h0, 1));
        vecs.push_back(V(0, 1,0,32'h10,32'h0,  1,0,32'h20,32'h0,    0,32'h0,        0,0,32'h20,32'h0,     0,32'h11,       1,32'h22, 1));
        vecs.push_back(V(0, 1,0,32'h10,32'h0,  1,0,32'h20,32'h0,    1,32'h33,       1,0,32'h10,32'h0,     0,32'h11,       0,32'h22, 1));
        vecs.push_back(V(0, 1,0,32'h10,32'h0,  1,0,32'h20,32'h0,    0,32'h0,        0,0,32'h10,32'h0,     1,32'h33,       0,32'h22, 0));
        vecs.push_back(V(0, 0,0,32'h10,32'h0,  0,0,32'h20,32'h0,    1,32'h44,       1,0,32'h20,32'h0,     0,32'h33,       0,32'h22, 0));
        vecs.push_back(V(0, 0,0,32'h10,32'h0,  0,0,32'h20,32'h0,    0,32'h0,        0,0,32'h20,32'h0,     0,32'h33,       1,32'h44, 0));
        // m1 write; m0 arrives mid-transaction and m1 inputs change while busy.
        vecs.push_back(V(0, 0,0,32'h0,32'h0,   1,1,32'h2000,32'h55AA, 0,32'h0,      0,0,32'h20,32'h0,     0,32'h33,       0,32'h44, 0));
        vecs.push_back(V(0, 1,0,32'h300,32'h9999, 1,1,32'h2000,32'h55AA, 0,32'h0,   1,1,32'h2000,32'h55AA, 0,32'h33,      0,32'h44, 1));
        vecs.push_back(V(0, 1,0,32'h300,32'h9999, 1,1,32'h2004,32'h55AA, 1,32'h0,   1,1,32'h2000,32'h55AA, 0,32'h33,      0,32'h44, 1));
        vecs.push_back(V(0, 1,0,32'h300,32'h9999, 0,0,32'h0,32'h0,    0,32'h0,      0,1,32'h2000,32'h55AA, 0,32'h33,      1,32'h0, 1));
        // m0 drops its request right after grant; transaction still completes.
        vecs.push_back(V(0, 0,0,32'h0,32'h0,   0,0,32'h0,32'h0,     0,32'h0,        1,0,32'h300,32'h9999, 0,32'h33,       0,32'h0, 0));
        vecs.push_back(V(0, 0,0,32'h0,32'h0,   0,0,32'h0,32'h0,     0,32'h0,        1,0,32'h300,32'h9999, 0,32'h33,       0,32'h0, 0));
        vecs.push_back(V(0, 0,0,32'h0,32'h0,   0,0,32'h0,32'h0,     1,32'hCAFE,     1,0,32'h300,32'h9999, 0,32'h33,       0,32'h0, 0));
        vecs.push_back(V(0, 0,0,32'h0,32'h0,   0,0,32'h0,32'h0,     0,32'h0,        0,0,32'h300,32'h9999, 1,32'hCAFE,     0,32'h0, 0));
        // Tie goes to m1 (m0 owned last); reset two cycles into busy aborts it.
        vecs.push_back(V(0, 1,0,32'h40,32'h0,  1,0,32'h50,32'h0,    0,32'h0,        0,0,32'h300,32'h9999, 0,32'hCAFE,     0,32'h0, 1));
        vecs.push_back(V(0, 1,0,32'h40,32'h0,  1,0,32'h50,32'h0,    0,32'h0,        1,0,32'h50,32'h0,     0,32'hCAFE,     0,32'h0, 1));
        vecs.push_back(V(0, 1,0,32'h40,32'h0,  1,0,32'h50,32'h0,    0,32'h0,        1,0,32'h50,32'h0,     0,32'hCAFE,     0,32'h0, 1));
        vecs.push_back(V(1, 1,0,32'h40,32'h0,  1,0,32'h50,32'h0,    0,32'h0,        0,0,32'h0,32'h0,      0,32'h0,        0,32'h0, 1));
        vecs.push_back(V(0, 1,0,32'h40,32'h0,  1,0,32'h50,32'h0,    0,32'h0,        0,0,32'h0,32'h0,      0,32'h0,        0,32'h0, 1));
        vecs.push_back(V(0, 1,0,32'h40,32'h0,  0,0,32'h50,32'h0,    1,32'h77,       1,0,32'h40,32'h0,     0,32'h0,        0,32'h0, 1));
        vecs.push_back(V(0, 0,0,32'h40,32'h0,  0,0,32'h50,32'h0,    0,32'h0,        0,0,32'h40,32'h0,     1,32'h77,       0,32'h0, 0));
        vecs.push_back(V(0, 0,0,32'h40,32'h0,  0,0,32'h50,32'h0,    0,32'h0,        0,0,32'h40,32'h0,     0,32'h77,       0,32'h0, 0));

        tick();
        tick();

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            m0_req = vecs[i].r0; m0_we = vecs[i].w0; m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
            m1_req = vecs[i].r1; m1_we = vecs[i].w1; m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1;
            s_ack = vecs[i].sa; s_rdata = vecs[i].sd;
            @(negedge clk);
            chk($sformatf("row%0d s_req", i),    {31'b0, s_req},  {31'b0, vecs[i].es});
            chk($sformatf("row%0d s_we", i),     {31'b0, s_we},   {31'b0, vecs[i].ew});
            chk($sformatf("row%0d s_addr", i),   s_addr,          vecs[i].ea);
            chk($sformatf("row%0d s_wdata", i),  s_wdata,         vecs[i].ed);
            chk($sformatf("row%0d m0_ack", i),   {31'b0, m0_ack}, {31'b0, vecs[i].k0});
            chk($sformatf("row%0d m0_rdata", i), m0_rdata,        vecs[i].q0);
            chk($sformatf("row%0d m1_ack", i),   {31'b0, m1_ack}, {31'b0, vecs[i].k1});
            chk($sformatf("row%0d m1_rdata", i), m1_rdata,        vecs[i].q1);
            chk($sformatf("row%0d errs", i),     {30'b0, m0_err, m1_err}, 32'h0);
            chk($sformatf("row%0d hold", i),     {31'b0, hold},   {31'b0, vecs[i].h});
            tick();
        end

        // Fetch with a bounded wait on the slave request, then a single ack pulse.
        rst = 0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h80;
        begin
            int waited;
            waited = 0;
            tick();
            while (!s_req && waited < 10) begin
                tick();
                waited++;
            end
            chk("fetch s_req seen", {31'b0, s_req}, 32'h1);
            chk("fetch s_addr", s_addr, 32'h80);
        end
        s_ack = 1; s_rdata = 32'h1234; m1_req = 0;
        tick();
        s_ack = 0; s_rdata = 0;
        @(negedge clk);
        chk("fetch m1_ack", {31'b0, m1_ack}, 32'h1);
        chk("fetch m1_rdata", m1_rdata, 32'h1234);
        chk("fetch m0_ack stays low", {31'b0, m0_ack}, 32'h0);
        chk("fetch s_req dropped", {31'b0, s_req}, 32'h0);
        tick();
        @(negedge clk);
        chk("fetch ack single pulse", {31'b0, m1_ack}, 32'h0);
        tick();

`ifdef ARB_TIMEOUT_EN
        // Slave never answers: abort four cycles after s_req rises.
        m0_req = 1; m0_we = 0; m0_addr = 32'h500;
        tick();
        m0_req = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("to busy%0d s_req", c), {31'b0, s_req}, 32'h1);
            chk($sformatf("to busy%0d ack", c), {31'b0, m0_ack}, 32'h0);
            tick();
        end
        @(negedge clk);
        chk("to ack", {31'b0, m0_ack}, 32'h1);
        chk("to err", {31'b0, m0_err}, 32'h1);
        chk("to rdata", m0_rdata, 32'h0);
        chk("to s_req", {31'b0, s_req}, 32'h0);
        tick();
        // Ack arriving on the limit cycle wins over the timeout.
        m0_req = 1;
        tick();
        m0_req = 0;
        for (int c = 0; c < 3; c++) tick();
        s_ack = 1; s_rdata = 32'hABCD;
        tick();
        s_ack = 0; s_rdata = 0;
        @(negedge clk);
        chk("limit ack", {31'b0, m0_ack}, 32'h1);
        chk("limit err", {31'b0, m0_err}, 32'h0);
        chk("limit rdata", m0_rdata, 32'hABCD);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Two-master, one-slave bus arbiter for the core's shared memory port.
- Master 0 is the execute stage (load/store); master 1 is instruction fetch.
- Serialises accesses with a registered req/ack handshake and alternates grants under contention.
- Drives hold_flag_o, which feeds the pipeline controller's hold_flag_ex_i to stall the pipe while a load/store is outstanding.

Parameters:
- TIMEOUT, 16, slave-response cycle limit; used only with ARB_TIMEOUT_EN; legal range 2..255.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- m0_req_i  input  1  execute-stage request; held until m0_ack_o.
- m0_we_i  input  1  1 = write, 0 = read.
- m0_addr_i  input  32  byte address.
- m0_wdata_i  input  32  write data.
- m0_rdata_o  output  32  read data; valid when m0_ack_o = 1.
- m0_ack_o  output  1  one-cycle completion pulse.
- m0_err_o  output  1  one-cycle timeout pulse; coincident with m0_ack_o.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_ack_o, m1_err_o: same as m0, for instruction fetch.
- s_req_o  output  1  slave request; held until s_ack_i.
- s_we_o  output  1  latched we.
- s_addr_o  output  32  latched address.
- s_wdata_o  output  32  latched write data.
- s_rdata_i  input  32  slave read data; valid with s_ack_i.
- s_ack_i  input  1  slave completion; single-cycle.
- hold_flag_o  output  1  pipeline hold request to the controller.

Behaviour:
- Reset: state IDLE; owner = 0; last_owner = 1; timeout counter = 0. All outputs are 0: s_req_o, s_we_o, s_addr_o, s_wdata_o, mX_ack_o, mX_err_o and mX_rdata_o.
- Reset is asynchronous. Asserting it mid-transaction drops s_req_o immediately. The aborted transaction is not acked.
- FSM states: IDLE and BUSY.
- IDLE:
  - If only one mX_req_i is high, grant that master.
  - If both are high, grant the master that is not last_owner (alternation). After reset, master 0 therefore wins the first tie.
  - On grant: latch owner and that master's we/addr/wdata into the s_* registers, set s_req_o = 1, go to BUSY. Request at cycle N gives s_req_o at N+1.
- BUSY:
  - s_* outputs are held constant.
  - On s_ack_i at cycle M: at M+1, mOwner_ack_o = 1 and mOwner_rdata_o = s_rdata_i (registered), s_req_o = 0, last_owner = owner, state = IDLE.
- The earliest next grant is evaluated in the IDLE cycle after the ack, so the minimum gap between two slave requests is one cycle.
- A master's req_i and inputs are ignored while another master owns the bus. They are sampled only at grant.
- If the owner drops req_i mid-transaction, the transaction still completes and the ack pulse is still issued.
- Non-owner ack/err outputs stay 0. Non-owner rdata outputs hold their last value.
- A master must not see ack for a request it has not made. Inputs are sampled only while IDLE.
- hold_flag_o = m0_req_i AND NOT m0_ack_o (combinational from the registered ack). It is high from request until the ack cycle, then low in the ack cycle.
- Ignore s_ack_i while in IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With it defined:
  - The counter clears on entry to BUSY and increments every BUSY cycle without s_ack_i.
  - When the counter reaches TIMEOUT-1 with no ack, the transaction aborts: next cycle mOwner_ack_o = 1, mOwner_err_o = 1, rdata = 0, s_req_o = 0, state = IDLE, last_owner updated.
  - If s_ack_i arrives in the same cycle as the limit, the ack wins and no err is raised.
- Without it: no counter is built, mX_err_o are tied to 0, and BUSY waits indefinitely.

Test Plan:
- Reset → m0 read 0x100 at cycle 2 → s_req_o=1 at cycle 3 with s_addr_o=0x100. s_ack_i at cycle 5 with rdata 0xDEADBEEF → m0_ack_o=1 and m0_rdata_o=0xDEADBEEF at cycle 6; hold_flag_o high cycles 2–5, low at cycle 6.
- m0 and m1 request in the same cycle after reset, held continuously → grants m0, m1, m0, m1; each slave request is separated by exactly one IDLE cycle.
- m1 writes 0x55AA to 0x2000; m0 raises req mid-BUSY → s_* stay at m1's values until ack; m0 is granted in the following IDLE cycle.
- m0 drops req the cycle after grant → slave transaction still runs; m0_ack_o pulses one cycle after s_ack_i.
- ARB_TIMEOUT_EN, TIMEOUT=4, slave never acks → ack and err pulse on the owner 4 cycles after s_req_o rises, rdata=0; a repeat run with s_ack_i on the limit cycle gives ack with err=0.
- Assert rst two cycles into BUSY → s_req_o=0 the same cycle; after release, a tie is granted to m0 first.
